// File: rtl/add8_reg.sv
// Byte-wide registered adder: ripple chain of full-adder cells feeding
// sum/carry/overflow registers that capture only on valid operands.

module add8_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module add8_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       carry_in,
  input  logic       in_valid,
  output logic [7:0] sum,
  output logic       carry,
  output logic       overflow,
  output logic       out_valid
);
  localparam int W = 8;

  logic [W:0]   c;
  logic [W-1:0] s;
  logic         v;

  assign c[0] = carry_in;

  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      add8_fa u_fa (
        .a_i(in1[i]),
        .b_i(in2[i]),
        .c_i(c[i]),
        .s_o(s[i]),
        .c_o(c[i+1])
      );
    end
  endgenerate

  // Carries into and out of the sign bit disagree exactly on signed overflow.
  assign v = c[W] ^ c[W-1];

  logic [W-1:0] sum_q, sum_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic         vld_q, vld_d;

  // Result registers hold unless the operands are valid, so junk on the
  // inputs during idle cycles never reaches the outputs.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    vld_d   = in_valid;
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[W];
      ovf_d   = v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_add8_reg.sv
// Bench for add8_reg: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results.

module tb_add8_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1, in2;
  logic       carry_in, in_valid;
  logic [7:0] sum;
  logic       carry, overflow, out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  add8_reg dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .carry_in(carry_in),
    .in_valid(in_valid), .sum(sum), .carry(carry), .overflow(overflow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: integer sum and signed-range test, not a ripple chain.
  int m_sum = 0, m_carry = 0, m_ovf = 0, m_vld = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum <= 0; m_carry <= 0; m_ovf <= 0; m_vld <= 0;
    end else begin
      m_vld <= int'(in_valid);
      if (in_valid) begin
        int t, sa, sb, ss;
        t  = int'(in1) + int'(in2) + int'(carry_in);
        sa = (in1 > 127) ? int'(in1) - 256 : int'(in1);
        sb = (in2 > 127) ? int'(in2) - 256 : int'(in2);
        ss = sa + sb + int'(carry_in);
        m_sum   <= t % 256;
        m_carry <= (t > 255) ? 1 : 0;
        m_ovf   <= (ss > 127 || ss < -128) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_sum", int'(sum), m_sum);
      chk("model_carry", int'(carry), m_carry);
      chk("model_ovf", int'(overflow), m_ovf);
      chk("model_vld", int'(out_valid), m_vld);
    end
  end

  // Drive operands now (just after an edge), then wait one edge for the result.
  task automatic op(input int a, input int b, input int ci, input int vld);
    in1 = 8'(a); in2 = 8'(b); carry_in = ci[0]; in_valid = vld[0];
    @(posedge clk); #1;
  endtask

  task automatic exp_out(input string nm, input int s, input int c, input int o, input int v);
    chk({nm, "_sum"}, int'(sum), s);
    chk({nm, "_carry"}, int'(carry), c);
    chk({nm, "_ovf"}, int'(overflow), o);
    chk({nm, "_vld"}, int'(out_valid), v);
  endtask

  initial begin
    rst = 1'b1;
    in1 = 8'd255; in2 = 8'd255; carry_in = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    exp_out("in_reset", 0, 0, 0, 0);
    rst = 1'b0;

    op(0, 0, 0, 1);     exp_out("zero", 0, 0, 0, 1);

    op(5, 0, 0, 1);     exp_out("5p0", 5, 0, 0, 1);
    op(5, 65, 0, 1);    exp_out("5p65", 70, 0, 0, 1);
    op(255, 65, 0, 1);  exp_out("255p65", 64, 1, 0, 1);
    op(255, 100, 0, 1); exp_out("255p100", 99, 1, 0, 1);

    op(255, 0, 1, 1);   exp_out("wrap256", 0, 1, 0, 1);
    op(255, 255, 1, 1); exp_out("max511", 255, 1, 0, 1);
    op(0, 0, 1, 1);     exp_out("cin_only", 1, 0, 0, 1);

    op(127, 1, 0, 1);   exp_out("ovf_pos", 128, 0, 1, 1);
    op(128, 128, 0, 1); exp_out("ovf_neg", 0, 1, 1, 1);
    op(200, 100, 0, 1); exp_out("no_ovf", 44, 1, 0, 1);

    op(10, 20, 0, 1);   exp_out("hold_a", 30, 0, 0, 1);
    op(1, 1, 0, 0);     exp_out("hold_b", 30, 0, 0, 0);
    op(7, 9, 1, 0);     exp_out("hold_c", 30, 0, 0, 0);

    // Asynchronous reset between edges, held across an edge with valid operands.
    op(5, 65, 0, 1);    exp_out("pre_rst", 70, 0, 0, 1);
    in1 = 8'd9; in2 = 8'd9; carry_in = 1'b0; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 exp_out("async_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    exp_out("rst_blocks", 0, 0, 0, 0);
    rst = 1'b0;
    op(3, 4, 0, 1);     exp_out("post_rst", 7, 0, 0, 1);
    op(0, 0, 0, 0);     exp_out("idle", 7, 0, 0, 0);

    @(posedge clk); #1;
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add8_reg.md
Name: add8_reg

Overview:
- 8-bit binary adder with carry-in and carry-out. Outputs are registered, so the sum is available one clock after the operands are presented.
- It is the byte-wide arithmetic primitive of the octet math datapath, used by wider adders and ALU paths.
- The core is a ripple chain of eight full-adder cells. The sum, carry-out and signed-overflow results are captured in output registers.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in1  input  8  operand A, unsigned
- in2  input  8  operand B, unsigned
- carry_in  input  1  carry into bit 0
- in_valid  input  1  operands valid this cycle; qualifies the capture
- sum  output  8  registered (in1 + in2 + carry_in) mod 256
- carry  output  1  registered carry out of bit 7
- overflow  output  1  registered two's-complement overflow
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset: while rst=1, sum=0, carry=0, overflow=0, out_valid=0.
  - Reset takes effect immediately, not on a clock edge.
  - Reset held across a clock edge blocks capture.
  - Reset asserted mid-operation discards any pending result.
- Combinational core: {c8, s[7:0]} = in1 + in2 + carry_in, a 9-bit result.
  - Ripple form per bit i: s[i] = a^b^c[i]; c[i+1] = a&b | a&c[i] | b&c[i]; c[0] = carry_in.
  - Signed overflow v = c[8] ^ c[7], equivalent to the operand signs matching while the sum sign differs.
- Capture: on each rising clk edge with rst=0:
  - out_valid <= in_valid.
  - If in_valid=1: sum <= s, carry <= c8, overflow <= v.
  - If in_valid=0: sum, carry and overflow hold their previous values.
- Latency: exactly 1 cycle from the in_valid=1 sample edge to the outputs.
  - Throughput is one add per cycle.
  - Back-to-back valid operands produce back-to-back results with no bubbles.
- No backpressure; the downstream consumer must accept the result on the cycle out_valid=1.
- Wrap-around:
  - The maximum sum, 255+255+1 = 511, gives sum=255, carry=1.
  - A sum of exactly 256 gives sum=0, carry=1.
- Operands changing between edges have no effect; only the values at the sampling edge matter.
- X/Z on the inputs while in_valid=0 must not disturb the held outputs.
- First edge after rst deasserts captures normally.

Test Plan:
- Reset then in1=0, in2=0, ci=0, valid=1 -> next cycle: sum=0, carry=0, overflow=0, out_valid=1. During rst=1, all outputs read 0 regardless of the inputs.
- Sequence of valid adds, one per cycle, ci=0 (each result appears one cycle after its operands):
  - 5+0 -> sum=5, carry=0
  - 5+65 -> sum=70, carry=0
  - 255+65 -> sum=64, carry=1
  - 255+100 -> sum=99, carry=1
- Carry-in and wrap:
  - 255+0, ci=1 -> sum=0, carry=1
  - 255+255, ci=1 -> sum=255, carry=1
  - 0+0, ci=1 -> sum=1, carry=0
- Signed overflow:
  - 127+1 -> sum=128, carry=0, overflow=1
  - 128+128 -> sum=0, carry=1, overflow=1
  - 200+100 -> sum=44, carry=1, overflow=0
- Hold and valid:
  - Add 10+20 with valid=1, then valid=0 while the operands change to 1+1 -> sum stays 30; out_valid goes 1 then 0.
- Async reset mid-stream: assert rst between clock edges after a result of 70 -> outputs go to 0 immediately. Release rst and apply 3+4 -> sum=7 one cycle later.
